// File: rtl/rvfpm_result_sched_if.sv
// Result channel between the FPU result scheduler and the CORE-V-XIF result port.
// The master drives a result and holds it until the slave accepts it with result_ready.
interface rvfpm_result_sched_if #(
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32,
    parameter int RD_WIDTH   = 5
);
    logic                  result_valid;
    logic                  result_ready;
    logic [X_ID_WIDTH-1:0] result_id;
    logic [FLEN-1:0]       result_data;
    logic [RD_WIDTH-1:0]   result_rd;
    logic                  result_we;

    modport master (
        output result_valid, result_id, result_data, result_rd, result_we,
        input  result_ready
    );

    modport slave (
        input  result_valid, result_id, result_data, result_rd, result_we,
        output result_ready
    );
endinterface

// File: rtl/rvfpm_result_sched.sv
// Result scheduler: tracks committed/killed instruction IDs, drops results of
// killed IDs and forwards committed results from two producers (execute = 0,
// load = 1) onto the single result channel with round-robin arbitration.
module rvfpm_result_sched #(
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic                    commit_valid,
    input  logic [X_ID_WIDTH-1:0]   commit_id,
    input  logic                    commit_kill,
    input  logic [1:0]              req_valid,
    input  logic [2*X_ID_WIDTH-1:0] req_id,
    input  logic [2*FLEN-1:0]       req_data,
    input  logic [2*RD_WIDTH-1:0]   req_rd,
    input  logic [1:0]              req_we,
    output logic [1:0]              req_ready,
    rvfpm_result_sched_if.master    res
);
    localparam int DEPTH = 2 ** X_ID_WIDTH;

    // Scoreboard and arbitration state
    logic [DEPTH-1:0]      committed_q, committed_d;
    logic [DEPTH-1:0]      killed_q, killed_d;
    logic                  rr_q, rr_d;

    // Output register
    logic                  out_valid_q, out_valid_d;
    logic [X_ID_WIDTH-1:0] out_id_q, out_id_d;
    logic [FLEN-1:0]       out_data_q, out_data_d;
    logic [RD_WIDTH-1:0]   out_rd_q, out_rd_d;
    logic                  out_we_q, out_we_d;

    // Arbitration signals
    logic [X_ID_WIDTH-1:0] id_w [2];
    logic [1:0]            drop;
    logic [1:0]            fwd;
    logic [1:0]            grant;
    logic                  winner;
    logic                  can_load;

    // Eligibility, drop detection and round-robin forward grant
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        drop     = '0;
        fwd      = '0;
        grant    = '0;
        winner   = 1'b0;
        can_load = !out_valid_q || res.result_ready;
        for (int i = 0; i < 2; i++) begin
            id_w[i] = req_id[i*X_ID_WIDTH +: X_ID_WIDTH];
            drop[i] = req_valid[i] & killed_q[id_w[i]];
            fwd[i]  = req_valid[i] & committed_q[id_w[i]] & ~killed_q[id_w[i]];
        end
        if (can_load && (fwd != 2'b00)) begin
            if (fwd == 2'b11) begin
                winner = rr_q;
            end else begin
                winner = fwd[1];
            end
            grant[winner] = 1'b1;
        end
        req_ready = drop | grant;
    end

    // Next-state for scoreboard, round-robin pointer and output register
    always_comb begin
        committed_d = committed_q;
        killed_d    = killed_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        out_we_d    = out_we_q;

        for (int i = 0; i < 2; i++) begin
            if (drop[i]) begin
                killed_d[id_w[i]] = 1'b0;
            end
        end

        if (grant != 2'b00) begin
            committed_d[id_w[winner]] = 1'b0;
            rr_d        = ~winner;
            out_valid_d = 1'b1;
            out_id_d    = id_w[winner];
            out_data_d  = winner ? req_data[2*FLEN-1:FLEN]         : req_data[FLEN-1:0];
            out_rd_d    = winner ? req_rd[2*RD_WIDTH-1:RD_WIDTH]   : req_rd[RD_WIDTH-1:0];
            out_we_d    = winner ? req_we[1]                       : req_we[0];
        end else if (res.result_ready) begin
            out_valid_d = 1'b0;
        end

        // A commit/kill this cycle is applied last so it wins over the grant or
        // drop clear of the same ID: it belongs to a new instance reusing the ID.
        if (commit_valid) begin
            if (commit_kill) begin
                killed_d[commit_id]    = 1'b1;
                committed_d[commit_id] = 1'b0;
            end else begin
                committed_d[commit_id] = 1'b1;
                killed_d[commit_id]    = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge ck) begin
        // NOTE: the scoreboard is plain flops, not RAM, so it is reset with
        // everything else; stale committed bits would leak across a reset.
        if (rst) begin
            committed_q <= '0;
            killed_q    <= '0;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            committed_q <= committed_d;
            killed_q    <= killed_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_we_q    <= out_we_d;
        end
    end

    assign res.result_valid = out_valid_q;
    assign res.result_id    = out_id_q;
    assign res.result_data  = out_data_q;
    assign res.result_rd    = out_rd_q;
    assign res.result_we    = out_we_q;
endmodule

// File: tb/tb_rvfpm_result_sched.sv
// Directed bench for rvfpm_result_sched: commit latency, round-robin order,
// kill drops, output hold under back-pressure, uncommitted wait and reset.
module tb_rvfpm_result_sched;
    logic        ck;
    logic        rst;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic [1:0]  req_valid;
    logic [7:0]  req_id;
    logic [63:0] req_data;
    logic [9:0]  req_rd;
    logic [1:0]  req_we;
    logic [1:0]  req_ready;

    int tests = 0;
    int fails = 0;

    rvfpm_result_sched_if #(.X_ID_WIDTH(4), .FLEN(32), .RD_WIDTH(5)) rif ();

    rvfpm_result_sched #(.X_ID_WIDTH(4), .FLEN(32), .RD_WIDTH(5)) dut (
        .ck           (ck),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .req_valid    (req_valid),
        .req_id       (req_id),
        .req_data     (req_data),
        .req_rd       (req_rd),
        .req_we       (req_we),
        .req_ready    (req_ready),
        .res          (rif.master)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Same ID on both requesters is illegal stimulus
    always @(negedge ck) begin
        if (req_valid == 2'b11) begin
            assert (req_id[3:0] !== req_id[7:4]) else begin
                fails++;
                $error("FAIL same_id: observed %0h expected distinct from %0h", req_id[7:4], req_id[3:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] id,
                           input logic [31:0] d, input logic [4:0] rd, input logic we);
        req_valid[i]        = v;
        req_id[i*4 +: 4]    = id;
        req_data[i*32 +: 32] = d;
        req_rd[i*5 +: 5]    = rd;
        req_we[i]           = we;
    endtask

    initial begin
        rst = 1'b1;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
        req_valid = '0; req_id = '0; req_data = '0; req_rd = '0; req_we = '0;
        rif.result_ready = 1'b1;

        // Reset state
        tick(); tick(); settle();
        chk("rst_valid", rif.result_valid, 0);
        chk("rst_id",    rif.result_id, 0);
        chk("rst_data",  rif.result_data, 0);
        chk("rst_rd",    rif.result_rd, 0);
        chk("rst_we",    rif.result_we, 0);
        chk("rst_ready", req_ready, 2'b00);
        rst = 1'b0;
        tick();

        // Commit and request in the same cycle: grant next cycle, result after
        commit(4'd3, 1'b0);
        set_req(0, 1'b1, 4'd3, 32'h3F800000, 5'd5, 1'b1);
        settle();
        chk("t1_ready_same", req_ready, 2'b00);
        tick(); settle();
        chk("t1_ready",     req_ready, 2'b01);
        chk("t1_no_valid",  rif.result_valid, 0);
        tick(); set_req(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0); settle();
        chk("t1_valid", rif.result_valid, 1);
        chk("t1_id",    rif.result_id, 3);
        chk("t1_data",  rif.result_data, 32'h3F800000);
        chk("t1_rd",    rif.result_rd, 5);
        chk("t1_we",    rif.result_we, 1);
        tick(); settle();
        chk("t1_done", rif.result_valid, 0);

        // Round robin from rr=0
        rst = 1'b1; tick(); rst = 1'b0;
        commit(4'd1, 1'b0); tick();
        commit(4'd2, 1'b0); tick();
        set_req(0, 1'b1, 4'd1, 32'h11111111, 5'd1, 1'b1);
        set_req(1, 1'b1, 4'd2, 32'h22222222, 5'd2, 1'b1);
        settle();
        chk("t2_ready_a", req_ready, 2'b01);
        tick(); set_req(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0); settle();
        chk("t2_ready_b", req_ready, 2'b10);
        chk("t2_id_a",    rif.result_id, 1);
        chk("t2_data_a",  rif.result_data, 32'h11111111);
        tick(); set_req(1, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0); settle();
        chk("t2_valid_b", rif.result_valid, 1);
        chk("t2_id_b",    rif.result_id, 2);
        chk("t2_rd_b",    rif.result_rd, 2);
        tick(); settle();
        chk("t2_idle", rif.result_valid, 0);
        // Single execute grant moves rr to 1
        commit(4'd8, 1'b0); tick();
        commit(4'd4, 1'b0);
        set_req(0, 1'b1, 4'd8, 32'h00000088, 5'd8, 1'b0);
        settle();
        chk("t2_ready_8", req_ready, 2'b01);
        tick(); set_req(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);
        commit(4'd5, 1'b0); settle();
        chk("t2_id_8", rif.result_id, 8);
        chk("t2_we_8", rif.result_we, 0);
        tick();
        set_req(0, 1'b1, 4'd4, 32'h44444444, 5'd4, 1'b1);
        set_req(1, 1'b1, 4'd5, 32'h55555555, 5'd5, 1'b1);
        settle();
        chk("t2_ready_c", req_ready, 2'b10);
        tick(); set_req(1, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0); settle();
        chk("t2_id_c",    rif.result_id, 5);
        chk("t2_ready_d", req_ready, 2'b01);
        tick(); set_req(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0); settle();
        chk("t2_id_d",   rif.result_id, 4);
        chk("t2_data_d", rif.result_data, 32'h44444444);
        tick(); settle();
        chk("t2_idle2", rif.result_valid, 0);

        // Kill drops silently and clears killed[]
        commit(4'd7, 1'b1);
        set_req(1, 1'b1, 4'd7, 32'h00000077, 5'd7, 1'b1);
        settle();
        chk("t3_ready_same", req_ready, 2'b00);
        tick(); settle();
        chk("t3_drop",     req_ready, 2'b10);
        chk("t3_no_valid", rif.result_valid, 0);
        tick(); settle();
        chk("t3_cleared",   req_ready, 2'b00);
        chk("t3_no_valid2", rif.result_valid, 0);
        tick(); settle();
        chk("t3_no_valid3", rif.result_valid, 0);
        set_req(1, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);

        // Output hold under back-pressure, then no bubble
        commit(4'd2, 1'b0); tick();
        commit(4'd6, 1'b0);
        rif.result_ready = 1'b0;
        set_req(0, 1'b1, 4'd2, 32'h00000022, 5'd2, 1'b1);
        settle();
        chk("t4_grant2", req_ready, 2'b01);
        tick(); set_req(0, 1'b1, 4'd6, 32'h66666666, 5'd6, 1'b1); settle();
        chk("t4_hold_valid0", rif.result_valid, 1);
        chk("t4_hold_id0",    rif.result_id, 2);
        chk("t4_hold_ready0", req_ready, 2'b00);
        for (int k = 0; k < 2; k++) begin
            tick(); settle();
            chk("t4_hold_id",    rif.result_id, 2);
            chk("t4_hold_data",  rif.result_data, 32'h00000022);
            chk("t4_hold_ready", req_ready, 2'b00);
        end
        rif.result_ready = 1'b1; settle();
        chk("t4_grant6", req_ready, 2'b01);
        tick(); set_req(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0); settle();
        chk("t4_valid6", rif.result_valid, 1);
        chk("t4_id6",    rif.result_id, 6);
        chk("t4_data6",  rif.result_data, 32'h66666666);
        tick(); settle();
        chk("t4_idle", rif.result_valid, 0);

        // Uncommitted request waits, then commit gives result two cycles later
        set_req(0, 1'b1, 4'd9, 32'h00000099, 5'd9, 1'b1);
        for (int k = 0; k < 20; k++) begin
            settle();
            chk("t5_wait_valid", rif.result_valid, 0);
            chk("t5_wait_ready", req_ready, 2'b00);
            tick();
        end
        commit(4'd9, 1'b0); settle();
        chk("t5_ready_same", req_ready, 2'b00);
        tick(); settle();
        chk("t5_ready",    req_ready, 2'b01);
        chk("t5_no_valid", rif.result_valid, 0);
        tick(); set_req(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0); settle();
        chk("t5_valid", rif.result_valid, 1);
        chk("t5_id",    rif.result_id, 9);
        tick();

        // Reset mid-transaction discards result and scoreboard
        rif.result_ready = 1'b0;
        commit(4'd10, 1'b0); tick();
        commit(4'd4, 1'b0);
        set_req(0, 1'b1, 4'd10, 32'hAAAAAAAA, 5'd10, 1'b1);
        settle();
        chk("t6_grant10", req_ready, 2'b01);
        tick(); set_req(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0); settle();
        chk("t6_valid10", rif.result_valid, 1);
        chk("t6_id10",    rif.result_id, 10);
        rst = 1'b1; tick(); rst = 1'b0; settle();
        chk("t6_rst_valid", rif.result_valid, 0);
        chk("t6_rst_id",    rif.result_id, 0);
        rif.result_ready = 1'b1;
        set_req(0, 1'b1, 4'd4, 32'h44444444, 5'd4, 1'b1);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t6_no_ready", req_ready, 2'b00);
            chk("t6_no_valid", rif.result_valid, 0);
            tick();
        end
        set_req(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
